bridge_status_arbiter: RTL and testbench
========================================

# bridge_status_arbiter

Arbitrates single-cycle register writes into the register block between the USB front-end and the bridge's flag-clear requests, replacing the combinational override in the top level. It buffers one front-end write, latches clear requests as pending bits, merges simultaneous clears, and computes read-modify-write data hazard-free against the status register. It sits in the usb_clk domain between the front-end and the register block, with clear requests already synchronised to that clock.

## Interface
- pADDR_WIDTH, 21: USB address width.
- pBYTECNT_SIZE, 2: byte-count bits; register address width is AW = pADDR_WIDTH-pBYTECNT_SIZE.
- pSTATUS_ADDR, 19'h0000A: register address of the bridge status byte.
- pSTARVE_LIMIT, 4: maximum consecutive clear grants while a front-end write waits (1..15).

Ports:
- clk  in  1  register clock (usb_clk_buf).
- rst  in  1  asynchronous, active-high reset.
- fe_reg_address  in  AW  front-end register address.
- fe_write_data  in  8  front-end write data.
- fe_reg_write  in  1  front-end write strobe, one cycle per write.
- clr_addr_req_n  in  1  active-low request to clear status bit 2 (addr_valid).
- clr_instr_req_n  in  1  active-low request to clear status bit 1 (instr_valid).
- status_i  in  8  current status register contents.
- reg_address_o  out  AW  arbitrated write address.
- write_data_o  out  8  arbitrated write data.
- reg_write_o  out  1  arbitrated write strobe.
- clr_addr_done_o  out  1  one-cycle pulse when a bit-2 clear is issued.
- clr_instr_done_o  out  1  one-cycle pulse when a bit-1 clear is issued.
- overflow_o  out  1  sticky flag: a front-end write was dropped.
- stats_o  out  32  present only with STATUS_ARB_STATS_EN.

## Operation
- Request capture: a falling edge on each clr_*_req_n sets its pending bit; the previous level is registered and initialises to 1. A held-low level does not re-trigger. An edge on an already-pending bit merges into it.
- FE buffer: one entry (valid, address, data), loaded on fe_reg_write.
- Arbitration, evaluated each edge, with at most one write issued:
  - If the FE buffer is valid and starve_cnt == pSTARVE_LIMIT, issue the FE write.
  - Otherwise, if any clear is pending, issue one clear write to pSTATUS_ADDR. Its data is eff_status & ~mask, where mask has bit 2 if addr is pending and bit 1 if instr is pending. Both pending bits are cleared in one write and both done pulses fire.
  - Otherwise, if the FE buffer is valid, issue the FE write.
- starve_cnt (4-bit):
  - Increments on each clear grant while the FE buffer is valid.
  - Clears on an FE grant or when the buffer is empty.
- eff_status:
  - Equals the last issued write data if the previous cycle issued a write to pSTATUS_ADDR, which covers both clear writes and FE writes.
  - Otherwise equals status_i. This covers the one-cycle register-block latency.
- Overflow: if fe_reg_write arrives while the buffer is valid and not being granted on the same edge, the new write is dropped and overflow_o sets. Only rst clears it.
- If the buffer is granted on the same edge as a new fe_reg_write, the buffer reloads with the new write.
- An FE write to pSTATUS_ADDR passes through unchanged and is not merged with clears.

## Timing
- Reset values:
  - All outputs 0 (stats_o 0).
  - Pending bits and buffer cleared; starve_cnt 0; previous-level registers 1.
- All outputs are registered.
- Latency from request to write:
  - A capture at edge k (FE load or pending set) allows the write to appear after edge k+1 at the earliest.
  - reg_write_o is high for exactly one cycle per write.
- Done pulses are coincident with the corresponding reg_write_o cycle.
- Idle cycles: reg_write_o = 0; reg_address_o and write_data_o hold their last values.
- Simultaneous events:
  - A clear edge and an FE strobe on the same edge are both captured; the clear wins the next grant unless the starvation limit applies.
  - A new clear edge on the same edge its bit is granted sets the bit pending again.
- Reset mid-operation: asynchronously drops all pending and buffered state. No partial write is emitted after rst deasserts.

## Configuration
- STATUS_ARB_STATS_EN defined:
  - stats_o[15:0] counts issued clear writes, saturating at 16'hFFFF.
  - stats_o[31:16] counts cycles the FE buffer is valid but not granted, saturating.
  - Both counters reset by rst.
- Undefined: the stats_o port and both counters are absent.

## Test plan
- Single clear: status_i=8'h06, pulse clr_addr_req_n low for one cycle at edge 1 → after edge 2, reg_write_o=1, reg_address_o=pSTATUS_ADDR, write_data_o=8'h02, clr_addr_done_o=1.
- Merged clear: both requests fall on the same edge with status_i=8'h07 → exactly one write of 8'h01, both done pulses, no second write.
- Back-to-back hazard: addr clear issued (status 8'h06 → 8'h02), instr edge one cycle later while status_i is still stale at 8'h06 → second write is 8'h00, not 8'h04.
- Starvation guard: FE write (addr 19'h1, data 8'hAA) buffered while clear requests alternate every cycle, pSTARVE_LIMIT=4 → FE write issued after exactly 4 clear grants.
- Overflow: two fe_reg_write strobes on consecutive edges while a clear is pending → first write issued later, second dropped, overflow_o=1 until rst; rst mid-burst → all outputs 0 the next cycle.

Source files
------------

// File: rtl/bridge_status_arbiter.sv
// bridge_status_arbiter
// Serialises single-cycle register writes from the USB front-end and the
// bridge's flag-clear requests into one write port of the register block.
// Clear requests become pending bits on their falling edge, simultaneous
// clears merge into one read-modify-write of the status byte, and the
// modify step uses the last issued status write while the register block
// has not yet reflected it. One front-end write is buffered; a second
// strobe while it waits is dropped and flagged on overflow_o.
// Optional build macro: STATUS_ARB_STATS_EN adds stats_o with a saturating
// clear-write count [15:0] and a saturating front-end wait-cycle count [31:16].
module bridge_status_arbiter #(
   parameter int pADDR_WIDTH   = 21,
   parameter int pBYTECNT_SIZE = 2,
   parameter logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] pSTATUS_ADDR = 19'h0000A,
   parameter int pSTARVE_LIMIT = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] fe_reg_address,
   input  logic [7:0]                           fe_write_data,
   input  logic                                 fe_reg_write,
   input  logic                                 clr_addr_req_n,
   input  logic                                 clr_instr_req_n,
   input  logic [7:0]                           status_i,
   output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address_o,
   output logic [7:0]                           write_data_o,
   output logic                                 reg_write_o,
   output logic                                 clr_addr_done_o,
   output logic                                 clr_instr_done_o,
   output logic                                 overflow_o
`ifdef STATUS_ARB_STATS_EN
   ,
   output logic [31:0]                          stats_o
`endif
);

   localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
   localparam logic [3:0] STARVE_LIMIT = 4'(pSTARVE_LIMIT);

   logic          prev_addr_r;
   logic          prev_instr_r;
   logic          pend_addr_r;
   logic          pend_instr_r;
   logic          fe_valid_r;
   logic [AW-1:0] fe_addr_r;
   logic [7:0]    fe_data_r;
   logic [3:0]    starve_cnt_r;

   logic          addr_fall_s;
   logic          instr_fall_s;
   logic          fe_grant_s;
   logic          clr_grant_s;
   logic [7:0]    eff_status_s;
   logic [7:0]    clr_mask_s;
   logic [7:0]    clr_data_s;

   // Edge detection, grant selection and clear-write data.
   always_comb begin
      addr_fall_s  = prev_addr_r & ~clr_addr_req_n;
      instr_fall_s = prev_instr_r & ~clr_instr_req_n;

      fe_grant_s  = 1'b0;
      clr_grant_s = 1'b0;
      if (fe_valid_r && (starve_cnt_r == STARVE_LIMIT)) begin
         fe_grant_s = 1'b1;
      end else if (pend_addr_r || pend_instr_r) begin
         clr_grant_s = 1'b1;
      end else if (fe_valid_r) begin
         fe_grant_s = 1'b1;
      end else begin
         fe_grant_s  = 1'b0;
         clr_grant_s = 1'b0;
      end

      // The register block shows a write one cycle late; use our own copy.
      if (reg_write_o && (reg_address_o == pSTATUS_ADDR)) begin
         eff_status_s = write_data_o;
      end else begin
         eff_status_s = status_i;
      end

      clr_mask_s = {5'b00000, pend_addr_r, pend_instr_r, 1'b0};
      clr_data_s = eff_status_s & ~clr_mask_s;
   end

   // Previous request levels and pending clear bits (merge and re-arm).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_addr_r  <= 1'b1;
         prev_instr_r <= 1'b1;
         pend_addr_r  <= 1'b0;
         pend_instr_r <= 1'b0;
      end else begin
         prev_addr_r  <= clr_addr_req_n;
         prev_instr_r <= clr_instr_req_n;
         pend_addr_r  <= (pend_addr_r & ~clr_grant_s) | addr_fall_s;
         pend_instr_r <= (pend_instr_r & ~clr_grant_s) | instr_fall_s;
      end
   end

   // One-entry front-end buffer with sticky drop detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fe_valid_r <= 1'b0;
         fe_addr_r  <= '0;
         fe_data_r  <= 8'h00;
         overflow_o <= 1'b0;
      end else begin
         if (fe_reg_write && (!fe_valid_r || fe_grant_s)) begin
            fe_valid_r <= 1'b1;
            fe_addr_r  <= fe_reg_address;
            fe_data_r  <= fe_write_data;
         end else if (fe_grant_s) begin
            fe_valid_r <= 1'b0;
         end else begin
            fe_valid_r <= fe_valid_r;
         end
         if (fe_reg_write && fe_valid_r && !fe_grant_s) begin
            overflow_o <= 1'b1;
         end
      end
   end

   // Count clear grants taken while a front-end write is waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= 4'd0;
      end else if (!fe_valid_r || fe_grant_s) begin
         starve_cnt_r <= 4'd0;
      end else if (clr_grant_s) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end
   end

   // Registered write port and done pulses; address/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_o      <= 1'b0;
         reg_address_o    <= '0;
         write_data_o     <= 8'h00;
         clr_addr_done_o  <= 1'b0;
         clr_instr_done_o <= 1'b0;
      end else begin
         reg_write_o      <= fe_grant_s | clr_grant_s;
         clr_addr_done_o  <= clr_grant_s & pend_addr_r;
         clr_instr_done_o <= clr_grant_s & pend_instr_r;
         if (fe_grant_s) begin
            reg_address_o <= fe_addr_r;
            write_data_o  <= fe_data_r;
         end else if (clr_grant_s) begin
            reg_address_o <= pSTATUS_ADDR;
            write_data_o  <= clr_data_s;
         end
      end
   end

`ifdef STATUS_ARB_STATS_EN
   // Saturating counters: clear writes issued, cycles a buffered write waited.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stats_o <= 32'h0000_0000;
      end else begin
         if (clr_grant_s && (stats_o[15:0] != 16'hFFFF)) begin
            stats_o[15:0] <= stats_o[15:0] + 16'd1;
         end
         if (fe_valid_r && !fe_grant_s && (stats_o[31:16] != 16'hFFFF)) begin
            stats_o[31:16] <= stats_o[31:16] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bridge_status_arbiter.sv
// Bench for bridge_status_arbiter: directed vector table, hand-written
// starvation and reset sequences, and random stimulus against a
// transaction-level reference model.
module tb_bridge_status_arbiter;

   localparam logic [18:0] ST    = 19'h0000A;
   localparam int          LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [18:0] fe_reg_address;
   logic [7:0]  fe_write_data;
   logic        fe_reg_write;
   logic        clr_addr_req_n;
   logic        clr_instr_req_n;
   logic [7:0]  status_i;
   logic [18:0] reg_address_o;
   logic [7:0]  write_data_o;
   logic        reg_write_o;
   logic        clr_addr_done_o;
   logic        clr_instr_done_o;
   logic        overflow_o;
`ifdef STATUS_ARB_STATS_EN
   logic [31:0] stats_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   bridge_status_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .fe_reg_address   (fe_reg_address),
      .fe_write_data    (fe_write_data),
      .fe_reg_write     (fe_reg_write),
      .clr_addr_req_n   (clr_addr_req_n),
      .clr_instr_req_n  (clr_instr_req_n),
      .status_i         (status_i),
      .reg_address_o    (reg_address_o),
      .write_data_o     (write_data_o),
      .reg_write_o      (reg_write_o),
      .clr_addr_done_o  (clr_addr_done_o),
      .clr_instr_done_o (clr_instr_done_o),
      .overflow_o       (overflow_o)
`ifdef STATUS_ARB_STATS_EN
      ,
      .stats_o          (stats_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fw;
      logic [18:0] fa;
      logic [7:0]  fd;
      logic        ca;
      logic        ci;
      logic [7:0]  st;
      logic [30:0] exp;
   } vec_t;

   vec_t vecs[18];

   typedef struct packed {
      logic [18:0] a;
      logic [7:0]  d;
   } fe_t;

   // reference model state
   fe_t         fe_q[$];
   bit          m_prev_a, m_prev_i, m_pa, m_pi, m_ovf, m_we, m_da, m_di;
   int          m_starve;
   logic [18:0] m_addr;
   logic [7:0]  m_data;

   function automatic logic [30:0] pk(input logic we, input logic [18:0] a,
                                      input logic [7:0] d, input logic da,
                                      input logic di, input logic ov);
      return {we, a, d, da, di, ov};
   endfunction

   function automatic vec_t mk(input logic fw, input logic [18:0] fa,
                               input logic [7:0] fd, input logic ca,
                               input logic ci, input logic [7:0] st,
                               input logic [30:0] exp);
      vec_t v;
      v.fw = fw; v.fa = fa; v.fd = fd; v.ca = ca; v.ci = ci; v.st = st; v.exp = exp;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [30:0] exp);
      logic [30:0] act;
      act = {reg_write_o, reg_address_o, write_data_o,
             clr_addr_done_o, clr_instr_done_o, overflow_o};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (we,addr,data,da,di,ovf)", name, act, exp);
      end
   endtask

   task automatic drive(input logic fw, input logic [18:0] fa, input logic [7:0] fd,
                        input logic ca, input logic ci, input logic [7:0] st);
      fe_reg_write    = fw;
      fe_reg_address  = fa;
      fe_write_data   = fd;
      clr_addr_req_n  = ca;
      clr_instr_req_n = ci;
      status_i        = st;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      bit          have_fe, any_clr, take_fe, take_clr;
      logic [7:0]  eff;
      logic [7:0]  mask;
      fe_t         e;
      if (rst) begin
         fe_q.delete();
         m_prev_a = 1'b1; m_prev_i = 1'b1; m_pa = 1'b0; m_pi = 1'b0;
         m_ovf = 1'b0; m_we = 1'b0; m_da = 1'b0; m_di = 1'b0;
         m_starve = 0; m_addr = 19'h0; m_data = 8'h00;
         return;
      end
      have_fe  = (fe_q.size() != 0);
      any_clr  = m_pa || m_pi;
      take_fe  = have_fe && ((m_starve == LIMIT) || !any_clr);
      take_clr = !take_fe && any_clr;
      eff      = (m_we && (m_addr == ST)) ? m_data : status_i;
      mask     = 8'((int'(m_pa) * 4) + (int'(m_pi) * 2));
      m_we     = take_fe || take_clr;
      m_da     = take_clr && m_pa;
      m_di     = take_clr && m_pi;
      if (take_fe) begin
         e      = fe_q.pop_front();
         m_addr = e.a;
         m_data = e.d;
      end else if (take_clr) begin
         m_addr = ST;
         m_data = eff & ~mask;
      end
      if (take_clr && have_fe) m_starve = m_starve + 1;
      else if (!have_fe || take_fe) m_starve = 0;
      if (fe_reg_write) begin
         if (fe_q.size() == 0) begin
            e.a = fe_reg_address;
            e.d = fe_write_data;
            fe_q.push_back(e);
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (take_clr) begin
         m_pa = 1'b0;
         m_pi = 1'b0;
      end
      if (m_prev_a && !clr_addr_req_n) m_pa = 1'b1;
      if (m_prev_i && !clr_instr_req_n) m_pi = 1'b1;
      m_prev_a = clr_addr_req_n;
      m_prev_i = clr_instr_req_n;
   endtask

   initial begin
      int          clr_seen;
      bit          fe_seen;
      logic [7:0]  fe_data_seen;

      // Directed table: inputs applied before an edge, outputs expected after it.
      vecs[0]  = mk(1'b0, 19'h0, 8'h00, 1'b0, 1'b1, 8'h06, pk(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 1'b0));
      vecs[1]  = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h06, pk(1'b1, ST,    8'h02, 1'b1, 1'b0, 1'b0));
      vecs[2]  = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h02, pk(1'b0, ST,    8'h02, 1'b0, 1'b0, 1'b0));
      vecs[3]  = mk(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 8'h07, pk(1'b0, ST,    8'h02, 1'b0, 1'b0, 1'b0));
      vecs[4]  = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h07, pk(1'b1, ST,    8'h01, 1'b1, 1'b1, 1'b0));
      vecs[5]  = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h01, pk(1'b0, ST,    8'h01, 1'b0, 1'b0, 1'b0));
      vecs[6]  = mk(1'b0, 19'h0, 8'h00, 1'b0, 1'b1, 8'h06, pk(1'b0, ST,    8'h01, 1'b0, 1'b0, 1'b0));
      vecs[7]  = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b0, 8'h06, pk(1'b1, ST,    8'h02, 1'b1, 1'b0, 1'b0));
      vecs[8]  = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h06, pk(1'b1, ST,    8'h00, 1'b0, 1'b1, 1'b0));
      vecs[9]  = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h00, pk(1'b0, ST,    8'h00, 1'b0, 1'b0, 1'b0));
      vecs[10] = mk(1'b1, 19'h1, 8'h55, 1'b0, 1'b1, 8'h06, pk(1'b0, ST,    8'h00, 1'b0, 1'b0, 1'b0));
      vecs[11] = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h06, pk(1'b1, ST,    8'h02, 1'b1, 1'b0, 1'b0));
      vecs[12] = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h02, pk(1'b1, 19'h1, 8'h55, 1'b0, 1'b0, 1'b0));
      vecs[13] = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h02, pk(1'b0, 19'h1, 8'h55, 1'b0, 1'b0, 1'b0));
      vecs[14] = mk(1'b1, 19'h2, 8'h11, 1'b0, 1'b1, 8'h06, pk(1'b0, 19'h1, 8'h55, 1'b0, 1'b0, 1'b0));
      vecs[15] = mk(1'b1, 19'h3, 8'h22, 1'b1, 1'b1, 8'h06, pk(1'b1, ST,    8'h02, 1'b1, 1'b0, 1'b1));
      vecs[16] = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h02, pk(1'b1, 19'h2, 8'h11, 1'b0, 1'b0, 1'b1));
      vecs[17] = mk(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h02, pk(1'b0, 19'h2, 8'h11, 1'b0, 1'b0, 1'b1));

      // Reset state
      rst = 1'b1;
      drive(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h00);
      tick();
      tick();
      check("reset_state", pk(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 1'b0));
      rst = 1'b0;
      tick();
      check("idle_after_reset", pk(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 1'b0));

      // Directed table
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].fw, vecs[i].fa, vecs[i].fd, vecs[i].ca, vecs[i].ci, vecs[i].st);
         tick();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Reset in the middle of a pending clear and a buffered write
      drive(1'b1, 19'h5, 8'h33, 1'b0, 1'b1, 8'h06);
      tick();
      check("pre_rst_capture", pk(1'b0, 19'h2, 8'h11, 1'b0, 1'b0, 1'b1));
      drive(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h06);
      rst = 1'b1;
      tick();
      check("rst_mid_burst", pk(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 1'b0));
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("post_rst_quiet%0d", i), pk(1'b0, 19'h0, 8'h00, 1'b0, 1'b0, 1'b0));
      end

      // Starvation guard: alternating clear edges every cycle behind a buffered write
      clr_seen     = 0;
      fe_seen      = 1'b0;
      fe_data_seen = 8'h00;
      for (int j = 0; j < 20 && !fe_seen; j++) begin
         drive((j == 0), 19'h1, 8'hAA, (j % 2 == 0) ? 1'b0 : 1'b1,
               (j % 2 == 1) ? 1'b0 : 1'b1, 8'h06);
         tick();
         if (reg_write_o) begin
            if (reg_address_o == 19'h1) begin
               fe_seen      = 1'b1;
               fe_data_seen = write_data_o;
            end else begin
               clr_seen++;
            end
         end
      end
      n_checks++;
      if (!fe_seen || clr_seen != LIMIT || fe_data_seen != 8'hAA) begin
         n_fail++;
         $display("FAIL starvation: fe_seen=%0d clears_before=%0d data=%h, required fe_seen=1 clears_before=%0d data=aa",
                  fe_seen, clr_seen, fe_data_seen, LIMIT);
      end
      drive(1'b0, 19'h0, 8'h00, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) tick();

      // Random stimulus against the reference model
      rst = 1'b1;
      model_step();
      tick();
      check("rand_reset", pk(m_we, m_addr, m_data, m_da, m_di, m_ovf));
      rst = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         drive(($urandom_range(0, 99) < 35),
               ($urandom_range(0, 3) == 0) ? ST : 19'($urandom_range(0, 31)),
               8'($urandom),
               ($urandom_range(0, 99) >= 30),
               ($urandom_range(0, 99) >= 30),
               8'($urandom));
         model_step();
         tick();
         check($sformatf("rand%0d", c), pk(m_we, m_addr, m_data, m_da, m_di, m_ovf));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
